// File: rtl/control_unit.sv
// Opcode-driven 13-bit accumulator controller with a RUN/HALTED FSM and a STORE-updated result register.
// Optional build macro CU_SATURATE_EN: INC/DEC/SHL saturate instead of wrapping.
module control_unit #(
  parameter int DATA_W = 13,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   in,
  output logic [DATA_W-1:0] o
);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  localparam logic [OP_W-1:0]   OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0]   OP_INC   = OP_W'(1);
  localparam logic [OP_W-1:0]   OP_STORE = OP_W'(2);
  localparam logic [OP_W-1:0]   OP_DEC   = OP_W'(3);
  localparam logic [OP_W-1:0]   OP_CLR   = OP_W'(4);
  localparam logic [OP_W-1:0]   OP_SHL   = OP_W'(5);
  localparam logic [OP_W-1:0]   OP_SHR   = OP_W'(6);
  localparam logic [OP_W-1:0]   OP_HALT  = OP_W'(7);
  localparam logic [DATA_W-1:0] ACC_MAX  = '1;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_acc, w_acc_nxt, w_o_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RUN;
      r_acc   <= '0;
      o       <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      o       <= w_o_nxt;
    end
  end

  // Opcodes with X/Z bits match no case item and fall to the NOP default.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_o_nxt     = o;
    if (r_state == S_RUN) begin
      case (in)
        OP_NOP:   ;
`ifdef CU_SATURATE_EN
        OP_INC:   w_acc_nxt = (r_acc == ACC_MAX) ? r_acc : r_acc + 1'b1;
        OP_DEC:   w_acc_nxt = (r_acc == '0) ? r_acc : r_acc - 1'b1;
        OP_SHL:   w_acc_nxt = r_acc[DATA_W-1] ? ACC_MAX : {r_acc[DATA_W-2:0], 1'b0};
`else
        OP_INC:   w_acc_nxt = r_acc + 1'b1;
        OP_DEC:   w_acc_nxt = r_acc - 1'b1;
        OP_SHL:   w_acc_nxt = {r_acc[DATA_W-2:0], 1'b0};
`endif
        OP_STORE: w_o_nxt   = r_acc;
        OP_CLR:   w_acc_nxt = '0;
        OP_SHR:   w_acc_nxt = {1'b0, r_acc[DATA_W-1:1]};
        OP_HALT:  w_state_nxt = S_HALTED;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues expected o values, a negedge monitor compares them.
module tb_control_unit;

  localparam logic [2:0] NOP = 3'd0, INC = 3'd1, STORE = 3'd2, DEC = 3'd3,
                         CLR = 3'd4, SHL = 3'd5, SHR = 3'd6, HALT = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  in  = 3'd0;
  logic [12:0] o;

  typedef struct {
    string       name;
    logic [12:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  control_unit dut (.clk(clk), .rst(rst), .in(in), .o(o));

  always #5 clk = ~clk;

  // Monitor: o is sampled on the falling edge, clear of the active edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (o !== e.exp) begin
          failures++;
          $display("FAIL %s: o=%0d expected=%0d", e.name, o, e.exp);
        end
      end
    end
  end

  task automatic op(input logic [2:0] c);
    @(negedge clk);
    in = c;
    @(posedge clk);
  endtask

  task automatic expect_o(input string name, input logic [12:0] v);
    exp_t e;
    e.name = name;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic store_chk(input string name, input logic [12:0] v);
    op(STORE);
    expect_o(name, v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in  = NOP;
    repeat (2) @(posedge clk);
    expect_o("reset_hold", 13'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int wait_cyc;
    repeat (2) @(posedge clk);
    expect_o("reset_state", 13'd0);
    @(negedge clk);
    rst = 1'b0;

    repeat (5) op(INC);
    store_chk("inc5", 13'd5);
    op(INC); op(INC); op(NOP);
    expect_o("hold5", 13'd5);

    // Asynchronous reset asserted mid-cycle, checked before the next rising edge.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 expect_o("rst_async", 13'd0);
    #47 rst = 1'b0;
    store_chk("rst_acc", 13'd0);

`ifdef CU_SATURATE_EN
    op(CLR); op(DEC); store_chk("dec_wrap", 13'd0);
    op(INC); store_chk("inc_wrap", 13'd1);
`else
    op(CLR); op(DEC); store_chk("dec_wrap", 13'd8191);
    op(INC); store_chk("inc_wrap", 13'd0);
`endif

    op(CLR); op(INC); op(INC); op(INC); op(SHL); op(SHL);
    store_chk("shl12", 13'd12);
    op(SHR); store_chk("shr6", 13'd6);

    op(CLR); op(INC);
    repeat (12) op(SHL);
    store_chk("acc4096", 13'd4096);
    op(SHL);
`ifdef CU_SATURATE_EN
    store_chk("shl_msb", 13'd8191);
`else
    store_chk("shl_msb", 13'd0);
`endif

    op(CLR); op(INC); store_chk("halt_pre", 13'd1);
    op(HALT); op(INC); store_chk("halted", 13'd1);
    op(DEC); op(CLR); store_chk("halted2", 13'd1);
    do_reset();
    op(INC); store_chk("after_halt", 13'd1);

    do_reset();
    repeat (4) begin
      @(negedge clk);
      in = 3'bxxx;
      @(posedge clk);
    end
    op(INC); store_chk("x_nop", 13'd1);
    op(NOP);

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
